// File: rtl/tone_synth_pkg.sv
// Shared constants and sizing helpers for the multi-channel tone synthesizer.
// The optional TONE_SYNC_STOP_EN macro is consumed by tone_channel.
package tone_synth_pkg;

  localparam int TONE_DIV_W      = 24;
  localparam int TONE_HALF_500HZ = 24000;
  localparam int TONE_HALF_1KHZ  = 12000;

  // Channel-select width; one bit minimum so a single-channel build still has a port.
  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Sigma-delta accumulator width: holds acc (< nch) plus a full popcount (<= nch).
  function automatic int acc_w(input int nch);
    return $clog2(nch + 1) + 1;
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone channel: half-period counter, pending half-period slot and output gate.
// With TONE_SYNC_STOP_EN defined the gate only follows vol_i while the phase is low.
module tone_channel
  import tone_synth_pkg::*;
#(
  parameter int DIV_W        = TONE_DIV_W,
  parameter int DEFAULT_HALF = TONE_HALF_500HZ
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  input  logic             vol_i,
  output logic             pend_o,
  output logic             tone_o
);

  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
  localparam logic [DIV_W-1:0] HALF_INIT = DIV_W'(DEFAULT_HALF);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] pend_val_q, pend_val_d;
  logic             phase_q, phase_d;
  logic             pend_q, pend_d;
  logic             half_zero, at_end, gate;

  assign half_zero = (half_q == '0);
  assign at_end    = (count_q == half_q - ONE);

  // A pending half-period is only committed on a boundary, so the rate never changes mid-half.
  always_comb begin
    count_d    = count_q;
    phase_d    = phase_q;
    half_d     = half_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    if (half_zero) begin
      count_d = '0;
      phase_d = 1'b0;
      if (pend_q) begin
        half_d = pend_val_q;
        pend_d = 1'b0;
      end
    end else if (at_end) begin
      count_d = '0;
      phase_d = ~phase_q;
      if (pend_q) begin
        half_d = pend_val_q;
        pend_d = 1'b0;
      end
    end else begin
      count_d = count_q + ONE;
    end
    if (load_i) begin
      pend_d     = 1'b1;
      pend_val_d = load_val_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      half_q     <= HALF_INIT;
      pend_val_q <= '0;
      phase_q    <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      half_q     <= half_d;
      pend_val_q <= pend_val_d;
      phase_q    <= phase_d;
      pend_q     <= pend_d;
    end
  end

`ifdef TONE_SYNC_STOP_EN
  // Sampling vol only during the low phase lets a started high half run to completion.
  logic gate_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gate_q <= 1'b0;
    end else if (!phase_q || half_zero) begin
      gate_q <= vol_i;
    end
  end
  assign gate = gate_q;
`else
  assign gate = vol_i;
`endif

  assign pend_o = pend_q;
  assign tone_o = gate & phase_q;

endmodule

// File: rtl/tone_synth.sv
// Multi-channel square-wave tone generator with valid/ready half-period updates and a
// first-order sigma-delta mix onto one speaker pin. Optional macro: TONE_SYNC_STOP_EN.
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter int NCH          = 2,
  parameter int DIV_W        = TONE_DIV_W,
  parameter int DEFAULT_HALF = TONE_HALF_500HZ,
  localparam int CH_W        = ch_w(NCH)
) (
  input  logic             clk_24_i,
  input  logic             rst_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic [DIV_W-1:0] cfg_half_i,
  input  logic [NCH-1:0]   vol_i,
  output logic [NCH-1:0]   tone_o,
  output logic             speaker_o
);

  localparam int               ACC_W   = acc_w(NCH);
  localparam logic [ACC_W-1:0] NCH_ACC = ACC_W'(NCH);

  logic [31:0]      ch_idx;
  logic [NCH-1:0]   pend, load;
  logic             pend_sel;
  logic [ACC_W-1:0] pop, mix_sum;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             speaker_q, speaker_d;

  assign ch_idx = 32'(cfg_ch_i);

  // Out-of-range channels never match, so they read as ready and the write is dropped.
  always_comb begin
    pend_sel = 1'b0;
    load     = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_idx == 32'(i)) begin
        pend_sel = pend[i];
        load[i]  = cfg_valid_i & ~rst_i & ~pend[i];
      end
    end
  end

  assign cfg_ready_o = ~rst_i & ~pend_sel;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tone_channel #(
      .DIV_W        (DIV_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk_i      (clk_24_i),
      .rst_i      (rst_i),
      .load_i     (load[g]),
      .load_val_i (cfg_half_i),
      .vol_i      (vol_i[g]),
      .pend_o     (pend[g]),
      .tone_o     (tone_o[g])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NCH; i++) begin
      pop = pop + ACC_W'(tone_o[i]);
    end
    mix_sum = acc_q + pop;
    if (mix_sum >= NCH_ACC) begin
      speaker_d = 1'b1;
      acc_d     = mix_sum - NCH_ACC;
    end else begin
      speaker_d = 1'b0;
      acc_d     = mix_sum;
    end
  end

  always_ff @(posedge clk_24_i) begin
    if (rst_i) begin
      acc_q     <= '0;
      speaker_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      speaker_q <= speaker_d;
    end
  end

  assign speaker_o = speaker_q;

endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth: directed steps plus a randomized stretch, checked every cycle against
// a boundary-time reference model. Follows TONE_SYNC_STOP_EN when it is defined.
module tb_tone_synth;

  localparam int NCH  = 2;
  localparam int HALF = 24000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready, speaker;
  logic [0:0]  cfg_ch;
  logic [23:0] cfg_half;
  logic [1:0]  vol, tone;

  logic        cfg3_valid, cfg3_ready, speaker3;
  logic [1:0]  cfg3_ch;
  logic [23:0] cfg3_half;
  logic [2:0]  vol3, tone3;

  always #5 clk = ~clk;

  tone_synth #(.NCH(NCH), .DIV_W(24), .DEFAULT_HALF(HALF)) u_dut (
    .clk_24_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_ch_i(cfg_ch), .cfg_half_i(cfg_half), .vol_i(vol), .tone_o(tone), .speaker_o(speaker));

  // Three-channel instance so that an out-of-range channel number is representable.
  tone_synth #(.NCH(3), .DIV_W(24), .DEFAULT_HALF(4)) u_dut3 (
    .clk_24_i(clk), .rst_i(rst), .cfg_valid_i(cfg3_valid), .cfg_ready_o(cfg3_ready),
    .cfg_ch_i(cfg3_ch), .cfg_half_i(cfg3_half), .vol_i(vol3), .tone_o(tone3), .speaker_o(speaker3));

  int checks = 0;
  int errors = 0;
  int t = 0;
  bit do_chk = 0;

  // Reference model: each channel remembers the absolute cycle that ends its current half.
  int m_half[NCH], m_last[NCH], m_pval[NCH];
  bit m_pend[NCH], m_ph[NCH], m_gate[NCH];
  int m_acc;
  bit m_sp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  function automatic bit exp_tone(input int i);
`ifdef TONE_SYNC_STOP_EN
    return m_gate[i] & m_ph[i];
`else
    return vol[i] & m_ph[i];
`endif
  endfunction

  function automatic bit exp_ready();
    if (rst) return 1'b0;
    return !m_pend[cfg_ch];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_half[i] = HALF; m_last[i] = HALF - 1; m_pval[i] = 0;
      m_pend[i] = 0; m_ph[i] = 0; m_gate[i] = 0;
    end
    m_acc = 0; m_sp = 0; t = 0;
  endtask

  task automatic advance();
    int  pop, s;
    bit  acc_ok;
    if (rst) begin
      model_reset();
      return;
    end
    pop = 0;
    for (int i = 0; i < NCH; i++) pop += int'(exp_tone(i));
    s = m_acc + pop;
    if (s >= NCH) begin m_sp = 1; m_acc = s - NCH; end
    else begin m_sp = 0; m_acc = s; end
    acc_ok = cfg_valid && exp_ready();
    for (int i = 0; i < NCH; i++) begin
`ifdef TONE_SYNC_STOP_EN
      if (!m_ph[i] || m_half[i] == 0) m_gate[i] = vol[i];
`endif
      if (m_half[i] == 0) begin
        m_ph[i] = 0;
        if (m_pend[i]) begin
          m_half[i] = m_pval[i]; m_pend[i] = 0; m_last[i] = t + m_half[i];
        end
      end else if (t == m_last[i]) begin
        m_ph[i] = ~m_ph[i];
        if (m_pend[i]) begin m_half[i] = m_pval[i]; m_pend[i] = 0; end
        m_last[i] = t + m_half[i];
      end
      if (acc_ok && int'(cfg_ch) == i) begin
        m_pend[i] = 1; m_pval[i] = int'(cfg_half);
      end
    end
    t++;
  endtask

  task automatic step();
    bit b3;
    #1;
    if (do_chk) begin
      chk("ready", cfg_ready, exp_ready());
      chk("tone0", tone[0], exp_tone(0));
      chk("tone1", tone[1], exp_tone(1));
      chk("speaker", speaker, m_sp);
      if (!rst && t < 200) begin
        b3 = bit'((t / 4) % 2);
        chk("tone3ch", tone3, {3{b3}});
      end
    end
    advance();
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cfg_ready && n < 100) begin step(); n++; end
    if (n >= 100) chk(tag, 32'd0, 32'd1);
  endtask

  int tb_acc;
  int spk_exp;

  initial begin
    rst = 1; cfg_valid = 0; cfg_ch = 0; cfg_half = 0; vol = 2'b01;
    cfg3_valid = 0; cfg3_ch = 0; cfg3_half = 0; vol3 = 3'b111;
    @(negedge clk);
    step(); step();
    rst = 0; do_chk = 1;

    #1; chk("rst_tone", tone, 2'b00); chk("rst_speaker", speaker, 1'b0);
    run_to(50);
    cfg3_valid = 1; cfg3_ch = 2'd3; cfg3_half = 24'd1;
    #1; chk("ch3_ready", cfg3_ready, 1'b1);
    step(); cfg3_valid = 0;

    run_to(100); vol = 2'b11;
    run_to(23999);
    #1; chk("low_end", tone[0], 1'b0);
    step();
    #1; chk("high_start", tone[0], 1'b1);

    run_to(24010); vol = 2'b01;
`ifdef TONE_SYNC_STOP_EN
    #1; chk("vol_fall", tone[1], 1'b1);
`else
    #1; chk("vol_fall", tone[1], 1'b0);
`endif

    run_to(24100 + int'($urandom_range(0, 50)));
    cfg_valid = 1; cfg_ch = 0; cfg_half = 24'd3;
    step();
    cfg_ch = 1;
    step();
    cfg_valid = 0; cfg_ch = 0;
    #1; chk("pend_blocks", cfg_ready, 1'b0);
    run_to(47999);
    #1; chk("ready_pre_apply", cfg_ready, 1'b0);
    step();
    #1; chk("ready_post_apply", cfg_ready, 1'b1);

    run_to(48010); vol = 2'b11;
    run_to(48020);
    for (int k = 0; k < 40; k++) begin
      spk_exp = ((t - 1 - 48000) / 3) % 2;
      #1; chk("spk_delay", speaker, spk_exp[0]);
      step();
    end

    run_to(48100);
    cfg_valid = 1; cfg_ch = 0; cfg_half = 24'd1;
    wait_ready("wait_h1"); step(); cfg_valid = 0;
    repeat (30) step();
    cfg_valid = 1; cfg_half = 24'd0;
    wait_ready("wait_h0"); step(); cfg_valid = 0;
    repeat (20) step();
    #1; chk("silent", tone[0], 1'b0);
    cfg_valid = 1; cfg_half = 24'd5;
    wait_ready("wait_h5");
    tb_acc = t;
    step(); cfg_valid = 0;
    #1; chk("h5_pending", cfg_ready, 1'b0);
    step();
    #1; chk("h5_applied", cfg_ready, 1'b1);
    run_to(tb_acc + 6);
    #1; chk("h5_low", tone[0], 1'b0);
    step();
    #1; chk("h5_high", tone[0], 1'b1);

    for (int k = 0; k < 400; k++) begin
      vol = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        cfg_valid = 1; cfg_ch = 1'($urandom); cfg_half = 24'($urandom_range(0, 6));
      end else begin
        cfg_valid = 0;
      end
      step();
    end

    vol = 2'b11;
    cfg_valid = 1; cfg_ch = 1; cfg_half = 24'd9;
    wait_ready("wait_h9"); step(); cfg_valid = 0;
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("post_rst_tone", tone, 2'b00);
    chk("post_rst_speaker", speaker, 1'b0);
    chk("post_rst_ready", cfg_ready, 1'b1);
    repeat (50) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
